// File: rtl/gray_code_counter_pkg.sv
// Shared Gray-code helpers and counter mode constants for the gray_code_counter slice.
// Functions operate on MAX_W-bit values; narrower codes are zero-extended.
package gray_pkg;

    localparam int MAX_W     = 32;
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic logic [MAX_W-1:0] bin_to_gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits leave the result unaffected.
    function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_code_counter_bin2gray_n.sv
// Combinational N-bit binary-to-Gray converter; width-generic successor of the 4-bit converter.
module bin2gray_n
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Up/down counter with a registered Gray image, parallel load, wrap/saturate mode,
// a combinational terminal-count flag and a registered one-cycle wrap pulse.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap
);

    localparam bit SAT = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] step_bin;
    logic [WIDTH-1:0] step_gray;
    logic [WIDTH-1:0] load_gray;

    assign step_bin = up ? bin + WIDTH'(1) : bin - WIDTH'(1);

    // Gray is encoded from the next binary value so both registers load on the same edge.
    bin2gray_n #(.WIDTH(WIDTH)) u_step_gray (
        .bin  (step_bin),
        .gray (step_gray)
    );

    bin2gray_n #(.WIDTH(WIDTH)) u_load_gray (
        .bin  (load_bin),
        .gray (load_gray)
    );

    assign tc = en & ((up & (bin == '1)) | (~up & (bin == '0)));

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            bin  <= load_bin;
            gray <= load_gray;
            wrap <= 1'b0;
        end else if (en) begin
            if (tc && SAT) begin
                wrap <= 1'b0;
            end else begin
                bin  <= step_bin;
                gray <= step_gray;
                wrap <= tc;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed self-checking bench: a 4-bit wrapping counter and an 8-bit saturating counter.
module tb_gray_code_counter;
    import gray_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, up_a, load_a;
    logic [3:0] load_bin_a, bin_a, gray_a;
    logic       tc_a, wrap_a;

    logic       rst_b, en_b, up_b, load_b;
    logic [7:0] load_bin_b, bin_b, gray_b;
    logic       tc_b, wrap_b;

    int checks = 0;
    int errors = 0;

    gray_code_counter #(.WIDTH(4), .SATURATE(MODE_WRAP)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .load(load_a),
        .load_bin(load_bin_a), .bin(bin_a), .gray(gray_a), .tc(tc_a), .wrap(wrap_a)
    );

    gray_code_counter #(.WIDTH(8), .SATURATE(MODE_SAT)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .load(load_b),
        .load_bin(load_bin_b), .bin(bin_b), .gray(gray_b), .tc(tc_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    initial begin
        logic [3:0] prev_a;
        logic [7:0] prev_b;

        rst_a = 1'b1; en_a = 1'b0; up_a = 1'b0; load_a = 1'b0; load_bin_a = '0;
        rst_b = 1'b1; en_b = 1'b0; up_b = 1'b0; load_b = 1'b0; load_bin_b = '0;

        // Reset and tc equation at zero
        tick(); tick();
        check("a_rst_bin", bin_a, 0);
        check("a_rst_gray", gray_a, 0);
        check("a_rst_wrap", wrap_a, 0);
        #1 check("a_tc_en0", tc_a, 0);
        en_a = 1'b1;
        #1 check("a_tc_down_at0", tc_a, 1);

        // Full up cycle with wrap
        up_a = 1'b1; rst_a = 1'b0;
        #1 check("a_tc_up_at0", tc_a, 0);
        prev_a = gray_a;
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) check("a_tc_up_atF", tc_a, 1);
            tick();
            check($sformatf("a_up_bin%0d", k), bin_a, 32'(k % 16));
            check($sformatf("a_up_gray%0d", k), gray_a, seq4[k % 16]);
            check($sformatf("a_up_ham%0d", k), $countones(gray_a ^ prev_a), 1);
            check($sformatf("a_up_wrap%0d", k), wrap_a, (k == 16) ? 1 : 0);
            prev_a = gray_a;
        end

        // Count down through the wrap
        up_a = 1'b0;
        tick();
        check("a_dn_bin1", bin_a, 4'hF);
        check("a_dn_gray1", gray_a, 4'h8);
        check("a_dn_wrap1", wrap_a, 1);
        tick();
        check("a_dn_bin2", bin_a, 4'hE);
        check("a_dn_gray2", gray_a, 4'h9);
        check("a_dn_wrap2", wrap_a, 0);
        tick();
        check("a_dn_bin3", bin_a, 4'hD);
        check("a_dn_gray3", gray_a, 4'hB);

        // Parallel load, with and without en
        en_a = 1'b0; load_a = 1'b1; load_bin_a = 4'hA;
        tick();
        check("a_ld_bin", bin_a, 4'hA);
        check("a_ld_gray", gray_a, 4'hF);
        check("a_ld_wrap", wrap_a, 0);
        load_bin_a = 4'hF;
        tick();
        check("a_ldF_bin", bin_a, 4'hF);
        en_a = 1'b1; up_a = 1'b1; load_bin_a = 4'h5;
        #1 check("a_tc_with_load", tc_a, 1);
        tick();
        check("a_ldbnd_bin", bin_a, 4'h5);
        check("a_ldbnd_gray", gray_a, 4'h7);
        check("a_ldbnd_wrap", wrap_a, 0);
        load_a = 1'b0; en_a = 1'b0;
        tick();
        check("a_hold_bin", bin_a, 4'h5);
        check("a_hold_gray", gray_a, 4'h7);

        // Reset mid-count beats load
        load_a = 1'b1; load_bin_a = 4'h7;
        tick();
        check("a_ld7_gray", gray_a, 4'h4);
        rst_a = 1'b1; en_a = 1'b1; load_bin_a = 4'hC;
        tick();
        check("a_rstld_bin", bin_a, 0);
        check("a_rstld_gray", gray_a, 0);
        check("a_rstld_wrap", wrap_a, 0);
        rst_a = 1'b0; load_a = 1'b0;
        tick();
        check("a_resume_bin", bin_a, 1);
        check("a_resume_gray", gray_a, 1);

        // Saturating 8-bit counter
        rst_b = 1'b1;
        tick(); tick();
        check("b_rst_bin", bin_b, 0);
        rst_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        prev_b = gray_b;
        for (int k = 1; k <= 255; k++) begin
            tick();
            check($sformatf("b_ham%0d", k), $countones(gray_b ^ prev_b), 1);
            check($sformatf("b_g2b%0d", k), gray_to_bin(32'(gray_b)), 32'(k));
            prev_b = gray_b;
        end
        check("b_top_bin", bin_b, 8'hFF);
        check("b_top_gray", gray_b, 8'h80);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("b_sat_bin%0d", k), bin_b, 8'hFF);
            check($sformatf("b_sat_gray%0d", k), gray_b, 8'h80);
            check($sformatf("b_sat_tc%0d", k), tc_b, 1);
            check($sformatf("b_sat_wrap%0d", k), wrap_b, 0);
        end
        up_b = 1'b0;
        #1 check("b_tc_rev", tc_b, 0);
        tick();
        check("b_rev_bin", bin_b, 8'hFE);
        check("b_rev_gray", gray_b, 8'h81);

        // Saturation at zero counting down
        load_b = 1'b1; load_bin_b = 8'h01;
        tick();
        load_b = 1'b0;
        tick();
        check("b_dn0_bin", bin_b, 0);
        tick();
        check("b_hold0_bin", bin_b, 0);
        check("b_hold0_gray", gray_b, 0);
        check("b_hold0_wrap", wrap_b, 0);
        check("b_hold0_tc", tc_b, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
